// File: rtl/pointer_draw_ctrl_pkg.sv
// Shared definitions for the pointer drawing controller: state encoding,
// colour constants and default screen geometry.
package pointer_pkg;

   // Sequencer states; the cycle is DRAW -> WAIT_TICK -> ERASE -> MOVE -> DRAW.
   typedef enum logic [1:0] {
      DRAW      = 2'd0,
      WAIT_TICK = 2'd1,
      ERASE     = 2'd2,
      MOVE      = 2'd3
   } state_t;

   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] BLACK = 3'b000;

   localparam int SCREEN_W_DEFAULT = 160;
   localparam int SCREEN_H_DEFAULT = 120;

   // Width of one scan counter axis; a 1-pixel box still needs a 1-bit counter.
   function automatic int scan_bits(input int box);
      return (box > 1) ? $clog2(box) : 1;
   endfunction

endpackage

// File: rtl/pointer_draw_ctrl_if.sv
// Pixel plot port toward the VGA adapter: one pixel offered per cycle,
// transferred when plot and plot_ready are both high.
interface pointer_draw_ctrl_if;
   logic [7:0] X;
   logic [7:0] Y;
   logic [2:0] colour_out;
   logic       plot;
   logic       plot_ready;

   modport master (output X, output Y, output colour_out, output plot, input plot_ready);
   modport slave  (input X, input Y, input colour_out, input plot, output plot_ready);
endinterface

// File: rtl/pointer_draw_ctrl_box_scan_counter.sv
// Row-major pixel scanner over a BOX_SIZE x BOX_SIZE box, shared by the draw
// and erase passes. col/row give the scan position that will be current in
// the next cycle, so the owner can load its registered pixel outputs from
// them; last flags that the current position is the final pixel.
module box_scan_counter
   import pointer_pkg::*;
#(
   parameter int BOX_SIZE = 4,
   parameter int CW       = scan_bits(BOX_SIZE)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          advance,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          last
);

   localparam logic [CW-1:0] MAX = CW'(BOX_SIZE - 1);

   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;

   // Next scan position: clear wins, otherwise step column first, wrap into row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else if (advance) begin
         if (col_q == MAX) begin
            col_d = '0;
            row_d = (row_q == MAX) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Scan position registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col  = col_d;
   assign row  = row_d;
   assign last = (col_q == MAX) && (row_q == MAX);

endmodule

// File: rtl/pointer_draw_ctrl.sv
// On-screen pointer sequencer: draws the box, waits for a frame tick, erases
// it, applies the direction inputs with edge clamping, then redraws.
// All plot outputs are registers loaded from next-cycle state, so nothing
// on the plot port depends combinationally on plot_ready.
module pointer_draw_ctrl
   import pointer_pkg::*;
#(
   parameter int         BOX_SIZE   = 4,
   parameter int         SCREEN_W   = SCREEN_W_DEFAULT,
   parameter int         SCREEN_H   = SCREEN_H_DEFAULT,
   parameter int         INIT_X     = 80,
   parameter int         INIT_Y     = 60,
   parameter logic [2:0] BOX_COLOUR = RED,
   parameter logic [2:0] BG_COLOUR  = BLACK
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       frame_tick,
   input  logic                       left,
   input  logic                       right,
   input  logic                       up,
   input  logic                       down,
   output logic                       busy,
   pointer_draw_ctrl_if.master        plot_bus
);

   localparam int CW = scan_bits(BOX_SIZE);

   // Largest legal top-left corner; compared in 9 bits so +1 never wraps.
   localparam logic [8:0] X_MAX = 9'(SCREEN_W - BOX_SIZE);
   localparam logic [8:0] Y_MAX = 9'(SCREEN_H - BOX_SIZE);

   state_t        state_q, state_d;
   logic [7:0]    pos_x_q, pos_x_d;
   logic [7:0]    pos_y_q, pos_y_d;
   logic          pending_q, pending_d;

   logic [7:0]    x_q, x_d;
   logic [7:0]    y_q, y_d;
   logic [2:0]    colour_q, colour_d;
   logic          plot_q, plot_d;
   logic          busy_q, busy_d;

   logic [CW-1:0] scan_col_d;
   logic [CW-1:0] scan_row_d;
   logic          scan_last;
   logic          scan_adv;
   logic          scan_clear;

   // A pixel moves only when it is actually offered and accepted.
   assign scan_adv   = plot_q && plot_bus.plot_ready;
   assign scan_clear = scan_adv && scan_last;

   box_scan_counter #(
      .BOX_SIZE (BOX_SIZE),
      .CW       (CW)
   ) u_scan (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (scan_clear),
      .advance (scan_adv),
      .col     (scan_col_d),
      .row     (scan_row_d),
      .last    (scan_last)
   );

   // Sequencer next state and the 1-deep pending tick.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      if (state_q != WAIT_TICK && frame_tick) begin
         pending_d = 1'b1;
      end
      case (state_q)
         DRAW: begin
            if (scan_clear) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            pending_d = 1'b0;
            if (frame_tick || pending_q) state_d = ERASE;
         end
         ERASE: begin
            if (scan_clear) state_d = MOVE;
         end
         MOVE: begin
            state_d = DRAW;
         end
         default: begin
            state_d = DRAW;
         end
      endcase
   end

   // Position update in MOVE; opposing requests cancel, each axis clamps at its edge.
   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      if (state_q == MOVE) begin
         if (left && !right && (pos_x_q != 8'd0)) begin
            pos_x_d = pos_x_q - 8'd1;
         end else if (right && !left && (({1'b0, pos_x_q} + 9'd1) <= X_MAX)) begin
            pos_x_d = pos_x_q + 8'd1;
         end
         if (up && !down && (pos_y_q != 8'd0)) begin
            pos_y_d = pos_y_q - 8'd1;
         end else if (down && !up && (({1'b0, pos_y_q} + 9'd1) <= Y_MAX)) begin
            pos_y_d = pos_y_q + 8'd1;
         end
      end
   end

   // Plot port contents for the next cycle, derived from next state and scan.
   always_comb begin
      plot_d   = (state_d == DRAW) || (state_d == ERASE);
      colour_d = (state_d == DRAW) ? BOX_COLOUR : BG_COLOUR;
      x_d      = pos_x_d + 8'(scan_col_d);
      y_d      = pos_y_d + 8'(scan_row_d);
      busy_d   = (state_d != WAIT_TICK);
   end

   // State, position and pending flag registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= DRAW;
         pos_x_q   <= 8'(INIT_X);
         pos_y_q   <= 8'(INIT_Y);
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         pending_q <= pending_d;
      end
   end

   // Registered plot port and busy flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_q      <= 8'd0;
         y_q      <= 8'd0;
         colour_q <= BG_COLOUR;
         plot_q   <= 1'b0;
         busy_q   <= 1'b1;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
      end
   end

   assign plot_bus.X          = x_q;
   assign plot_bus.Y          = y_q;
   assign plot_bus.colour_out = colour_q;
   assign plot_bus.plot       = plot_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_pointer_draw_ctrl.sv
// Directed bench for pointer_draw_ctrl: draw after reset, a full move with
// timing, edge clamping, plot_ready stalls, pending tick and mid-erase reset.
module tb_pointer_draw_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic frame_tick;
   logic left, right, up, down;
   logic busy;

   pointer_draw_ctrl_if pbus();

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   pointer_draw_ctrl #(
      .BOX_SIZE   (4),
      .SCREEN_W   (160),
      .SCREEN_H   (120),
      .INIT_X     (80),
      .INIT_Y     (60),
      .BOX_COLOUR (3'b100),
      .BG_COLOUR  (3'b000)
   ) dut (
      .clock      (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .left       (left),
      .right      (right),
      .up         (up),
      .down       (down),
      .busy       (busy),
      .plot_bus   (pbus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Walks n pixels of a box starting at the current negedge; optional
   // plot_ready stall pattern 1,0,0,1 and frame_tick pulses at pixel ta/tb.
   task automatic check_box(input string tag, input int x0, input int y0, input logic [2:0] col,
                            input int n, input bit stall, input int ta, input int tb);
      int i = 0;
      int k = 0;
      bit [3:0] pat = 4'b1001;
      logic [19:0] exp_v;
      while (i < n && k < 200) begin
         exp_v = {1'b1, 8'(x0 + i % 4), 8'(y0 + i / 4), col};
         chk($sformatf("%s_px%0d", tag, i),
             {12'd0, pbus.plot, pbus.X, pbus.Y, pbus.colour_out}, {12'd0, exp_v});
         frame_tick      = (i == ta) || (i == tb);
         pbus.plot_ready = stall ? pat[k % 4] : 1'b1;
         if (pbus.plot_ready) i++;
         k++;
         @(negedge clk);
      end
      frame_tick      = 1'b0;
      pbus.plot_ready = 1'b1;
      chk($sformatf("%s_count", tag), i, n);
   endtask

   // Erase at (ex,ey), one MOVE cycle, draw at (nx,ny); ends in WAIT_TICK.
   task automatic full_move(input string tag, input bit do_tick, input int ex, input int ey,
                            input int nx, input int ny, input bit stall, input int ta,
                            input int tb, output int len);
      int t0;
      frame_tick = do_tick;
      @(negedge clk);
      frame_tick = 1'b0;
      t0 = cyc;
      check_box({tag, "_erase"}, ex, ey, 3'b000, 16, 1'b0, -1, -1);
      chk({tag, "_move_plot"}, pbus.plot, 1'b0);
      chk({tag, "_move_busy"}, busy, 1'b1);
      @(negedge clk);
      check_box({tag, "_draw"}, nx, ny, 3'b100, 16, stall, ta, tb);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_plot"}, pbus.plot, 1'b0);
      len = cyc - t0;
   endtask

   // Unchecked move used to walk the pointer toward an edge.
   task automatic do_move();
      int n = 0;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("walk_done", busy, 1'b0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_X"}, pbus.X, 8'd0);
      chk({tag, "_Y"}, pbus.Y, 8'd0);
      chk({tag, "_colour"}, pbus.colour_out, 3'b000);
      chk({tag, "_plot"}, pbus.plot, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
   endtask

   initial begin
      int len;
      reset_n         = 1'b0;
      frame_tick      = 1'b0;
      left            = 1'b0;
      right           = 1'b0;
      up              = 1'b0;
      down            = 1'b0;
      pbus.plot_ready = 1'b1;

      // Reset values while reset_n is low.
      repeat (3) @(negedge clk);
      chk_reset("rst");

      // First box after reset at (80..83, 60..63) in red.
      reset_n = 1'b1;
      @(negedge clk);
      check_box("init_draw", 80, 60, 3'b100, 16, 1'b0, -1, -1);
      chk("init_idle_busy", busy, 1'b0);
      chk("init_idle_plot", pbus.plot, 1'b0);
      $display("step init_draw done");

      // One move right: 33 cycles from ERASE entry to WAIT_TICK.
      right = 1'b1;
      full_move("right", 1'b1, 80, 60, 81, 60, 1'b0, -1, -1, len);
      chk("right_len", len, 33);
      right = 1'b0;
      $display("step move_right len=%0d", len);

      // Walk to the top-left corner, then push further: clamps at (0,0).
      left = 1'b1;
      up   = 1'b1;
      for (int m = 0; m < 85; m++) do_move();
      full_move("clamp_lo", 1'b1, 0, 0, 0, 0, 1'b0, -1, -1, len);
      left = 1'b0;
      up   = 1'b0;
      $display("step clamp_low");

      // Walk to the bottom-right limit (156,116), then push further.
      right = 1'b1;
      down  = 1'b1;
      for (int m = 0; m < 160; m++) do_move();
      full_move("clamp_hi", 1'b1, 156, 116, 156, 116, 1'b0, -1, -1, len);
      right = 1'b0;
      down  = 1'b0;
      $display("step clamp_high");

      // plot_ready stalls during DRAW: outputs hold, no pixel lost or repeated.
      full_move("stall", 1'b1, 156, 116, 156, 116, 1'b1, -1, -1, len);
      $display("step stall");

      // Two ticks during DRAW with left=right=1, up=1: exactly one extra move.
      left  = 1'b1;
      right = 1'b1;
      up    = 1'b1;
      full_move("dtick1", 1'b1, 156, 116, 156, 115, 1'b0, 3, 9, len);
      full_move("dtick2", 1'b0, 156, 115, 156, 114, 1'b0, -1, -1, len);
      repeat (5) @(negedge clk);
      chk("dtick_no_third_busy", busy, 1'b0);
      chk("dtick_no_third_plot", pbus.plot, 1'b0);
      left  = 1'b0;
      right = 1'b0;
      up    = 1'b0;
      $display("step double_tick");

      // Reset in the middle of ERASE with scan at pixel 7.
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check_box("mid_erase", 156, 114, 3'b000, 7, 1'b0, -1, -1);
      reset_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_box("restart_draw", 80, 60, 3'b100, 16, 1'b0, -1, -1);
      chk("restart_idle_busy", busy, 1'b0);
      $display("step mid_erase_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
